// File: rtl/breakout_debounce_multi.sv
// breakout_debounce_multi: N-channel button conditioner (sync, debounce, press/release, repeat).
// Optional hold-to-repeat pulses when BREAKOUT_DEBOUNCE_REPEAT_EN is defined.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   btn_in       raw asynchronous button levels, active-high
//   btn_level    debounced level per channel
//   btn_press    one-cycle pulse on accepted 0->1
//   btn_release  one-cycle pulse on accepted 1->0
//   btn_repeat   one-cycle auto-repeat pulse while held (0 without the macro)
module breakout_debounce_multi #(
  parameter int NUM_CH        = 3,
  parameter int DEBOUNCE_TIME = 10000,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic [NUM_CH-1:0] btn_release,
  output logic [NUM_CH-1:0] btn_repeat
);

  localparam int MAX_A = (DEBOUNCE_TIME > REPEAT_DELAY) ?
                         DEBOUNCE_TIME : REPEAT_DELAY;
  localparam int MAX_T = (MAX_A > REPEAT_PERIOD) ?
                         MAX_A : REPEAT_PERIOD;
  localparam int CNT_W = $clog2(MAX_T) + 1;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_TIME - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] level_q;
  logic [NUM_CH-1:0] level_d;
  logic [NUM_CH-1:0] press_q;
  logic [NUM_CH-1:0] press_d;
  logic [NUM_CH-1:0] release_q;
  logic [NUM_CH-1:0] release_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  // Debounce: count consecutive cycles the synchronised input
  // disagrees with the accepted level; any agreement restarts.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BREAKOUT_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0]  rcnt_q [NUM_CH];
  logic [CNT_W-1:0]  rcnt_d [NUM_CH];
  logic [NUM_CH-1:0] phase_q;
  logic [NUM_CH-1:0] phase_d;
  logic [NUM_CH-1:0] rep_q;
  logic [NUM_CH-1:0] rep_d;
  logic [CNT_W-1:0]  lim;

  // The repeat counter runs only while the level stays high and
  // is not about to fall, so a release edge kills it at once.
  // The level was 0 before a press, so r is already 0 then.
  always_comb begin
    phase_d = '0;
    rep_d   = '0;
    lim     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rcnt_d[i] = '0;
      if (level_q[i] && level_d[i]) begin
        lim = phase_q[i] ? RP_LAST : RD_LAST;
        if (rcnt_q[i] == lim) begin
          rep_d[i]   = 1'b1;
          phase_d[i] = 1'b1;
        end else begin
          rcnt_d[i]  = rcnt_q[i] + ONE;
          phase_d[i] = phase_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      rep_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rcnt_q[i] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      rep_q   <= rep_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  assign btn_repeat = rep_q;
`else
  assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_breakout_debounce_multi.sv
// tb_breakout_debounce_multi: directed and random stimulus for
// breakout_debounce_multi against a sample-history reference model.
module tb_breakout_debounce_multi;

  localparam int N  = 3;
  localparam int DT = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  breakout_debounce_multi #(
    .NUM_CH       (N),
    .DEBOUNCE_TIME(DT),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: raw input seen at each clock edge since reset.
  bit [N-1:0] hist [$];
  bit [N-1:0] mlevel;
  bit [N-1:0] mpress;
  bit [N-1:0] mrel;
  bit [N-1:0] mrep;
  int         msince [N];

`ifdef BREAKOUT_DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [N-1:0] got,
                     input logic [N-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("level",   btn_level,   mlevel);
    chk("press",   btn_press,   mpress);
    chk("release", btn_release, mrel);
    chk("repeat",  btn_repeat,  mrep);
  endtask

  task automatic model_clear();
    hist.delete();
    mlevel = '0;
    mpress = '0;
    mrel   = '0;
    mrep   = '0;
    for (int c = 0; c < N; c++) msince[c] = 0;
  endtask

  // The synchronised value lags the input by two edges; a new
  // level is accepted once DT consecutive synced samples disagree.
  task automatic tick();
    int n;
    bit flip;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      hist.push_back(btn_in);
      n = hist.size();
      mpress = '0;
      mrel   = '0;
      mrep   = '0;
      for (int c = 0; c < N; c++) begin
        flip = (n >= DT + 2);
        if (flip) begin
          for (int j = 2; j <= DT + 1; j++) begin
            if (hist[n-1-j][c] == mlevel[c]) flip = 1'b0;
          end
        end
        if (flip) begin
          mlevel[c] = ~mlevel[c];
          mpress[c] = mlevel[c];
          mrel[c]   = ~mlevel[c];
          msince[c] = 0;
        end else if (mlevel[c]) begin
          msince[c]++;
          if (REP_ON && (msince[c] == RD ||
              (msince[c] > RD && (msince[c] - RD) % RP == 0)))
            mrep[c] = 1'b1;
        end
      end
      if (hist.size() > 16) void'(hist.pop_front());
    end
    #1 check_all();
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    btn_in = v;
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    model_clear();
    #1 check_all();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    #2;
    // reset with all buttons held, then release reset
    btn_in = 3'b111;
    pulse_reset(3);
    hold(3'b111, 10);
    hold(3'b000, 10);

    // clean edge on ch0, hold, drop
    hold(3'b001, 20);
    hold(3'b000, 10);

    // glitch on ch1 then bounce then stable
    hold(3'b010, 3);
    hold(3'b000, 10);
    hold(3'b010, 1);
    hold(3'b000, 1);
    hold(3'b010, 1);
    hold(3'b000, 1);
    hold(3'b010, 10);
    hold(3'b000, 10);

    // ch0/ch2 rise together while ch1 bounces
    for (int k = 0; k < 12; k++) begin
      hold({1'b1, k[0], 1'b1}, 1);
    end
    hold(3'b000, 10);

    // reset in the middle of a hold
    hold(3'b001, 9);
    pulse_reset(1);
    hold(3'b001, 10);
    hold(3'b000, 10);

    // long hold for auto-repeat, then release
    hold(3'b001, 6 + 25);
    hold(3'b000, 12);

    // random slowly varying inputs with rare resets
    for (int k = 0; k < 500; k++) begin
      logic [N-1:0] v;
      v = btn_in;
      if ($urandom_range(0, 4) == 0)
        v[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        btn_in = v;
        pulse_reset($urandom_range(1, 3));
      end else begin
        hold(v, 1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
